// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the bus arbiter.
//   - Arbiter state encoding (IDLE/GRANT/TURN) as 2-bit constants and a typed enum.
//   - Requester index constants naming the drivers of the shared 16-bit data bus.
package cpu_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StGrant = ST_GRANT,
    StTurn  = ST_TURN
  } arb_state_e;

  // Bus driver slots on the arbiter's req/gnt vectors.
  localparam int unsigned REQ_DEC  = 0;
  localparam int unsigned REQ_REG  = 1;
  localparam int unsigned REQ_ALU  = 2;
  localparam int unsigned REQ_LDSR = 3;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search (combinational).
//   req  in  N    request vector
//   ptr  in  IDW  index with highest priority this round
//   any  out 1    at least one request is set
//   idx  out IDW  first set request at or above ptr, wrapping N-1 -> 0
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);

  // The upper copy holds the wrapped-around candidates, so the lowest qualifying bit of the
  // doubled vector at or above ptr is the round-robin winner.
  logic [2*N-1:0] dbl;
  assign dbl = {req, req};

  always_comb begin
    any = 1'b0;
    idx = '0;
    // Descending scan: the last hit written is the lowest qualifying position.
    for (int j = 2 * N - 1; j >= 0; j--) begin
      if (dbl[j] && (j >= int'(ptr))) begin
        any = 1'b1;
        idx = IDW'(j % N);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared 16-bit tri-state data bus.
// Grants one driver at a time, inserts one dead cycle between tenures and cuts a tenure after
// MAX_HOLD consecutive grant cycles (0 = unlimited).
//   clk       in   1    rising-edge clock
//   reset     in   1    asynchronous active-low reset
//   req       in   N    level requests, held for the whole transfer
//   gnt       out  N    registered grant, one-hot or zero
//   owner     out  IDW  index of the grant holder, valid while bus_busy
//   bus_busy  out  1    any gnt bit set
//   hold_err  out  1    one-cycle pulse when a tenure was cut by the hold limit
module bus_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned IDW      = 2,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] owner,
  output logic           bus_busy,
  output logic           hold_err
);

  localparam int unsigned CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(N - 1);

  arb_state_e     state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           herr_q, herr_d;

  logic           pick_any;
  logic [IDW-1:0] pick_idx;
  logic           limit_hit;

  rr_pick #(
    .N  (N),
    .IDW(IDW)
  ) u_rr_pick (
    .req(req),
    .ptr(ptr_q),
    .any(pick_any),
    .idx(pick_idx)
  );

  // cnt_q counts completed grant cycles minus one during the current tenure.
  assign limit_hit = (MAX_HOLD != 0) && (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    herr_d  = 1'b0;

    unique case (state_q)
      StIdle, StTurn: begin
        if (pick_any) begin
          state_d         = StGrant;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          owner_d         = pick_idx;
          cnt_d           = '0;
        end else begin
          state_d = StIdle;
          gnt_d   = '0;
        end
      end
      StGrant: begin
        if (!req[owner_q] || limit_hit) begin
          // Release beats timeout when both happen on the same edge.
          herr_d  = req[owner_q];
          state_d = StTurn;
          gnt_d   = '0;
          // The outgoing owner drops to lowest priority for the next selection.
          ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + IDW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      herr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      herr_q  <= herr_d;
    end
  end

  assign gnt      = gnt_q;
  assign owner    = owner_q;
  assign bus_busy = |gnt_q;
  assign hold_err = herr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (MAX_HOLD=8 and MAX_HOLD=3) checked against a
// tenure-level reference model, spec vector tables and hand-written corner sequences.
module tb_bus_arbiter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req8, req3;
  logic [3:0] gnt8, gnt3;
  logic [1:0] owner8, owner3;
  logic       busy8, busy3, herr8, herr3;

  always #5 clk = ~clk;

  bus_arbiter #(.N(4), .IDW(2), .MAX_HOLD(8)) dut8 (
    .clk(clk), .reset(reset), .req(req8), .gnt(gnt8), .owner(owner8),
    .bus_busy(busy8), .hold_err(herr8)
  );

  bus_arbiter #(.N(4), .IDW(2), .MAX_HOLD(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .gnt(gnt3), .owner(owner3),
    .bus_busy(busy3), .hold_err(herr3)
  );

  int tests = 0;
  int fails = 0;

  // mode: 0 idle, 1 owned, 2 dead cycle; tenure = grant cycles served so far.
  typedef struct {
    int         mode;
    int         owner;
    int         ptr;
    int         tenure;
    logic [3:0] gnt;
    logic       herr;
  } model_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       herr;
  } vec_t;

  model_t m8, m3;

  function automatic model_t mreset();
    model_t n;
    n.mode = 0; n.owner = 0; n.ptr = 0; n.tenure = 0; n.gnt = '0; n.herr = 1'b0;
    return n;
  endfunction

  function automatic int pick(logic [3:0] r, int ptr);
    for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic model_t mstep(model_t m, logic [3:0] r, int maxhold);
    model_t n = m;
    n.herr = 1'b0;
    if (m.mode == 1) begin
      if (!r[m.owner] || (maxhold != 0 && m.tenure == maxhold)) begin
        n.herr = r[m.owner];
        n.mode = 2;
        n.ptr  = (m.owner + 1) % N;
        n.gnt  = '0;
      end else begin
        n.tenure = m.tenure + 1;
      end
    end else begin
      int w = pick(r, m.ptr);
      n.gnt = '0;
      if (w >= 0) begin
        n.mode = 1; n.owner = w; n.tenure = 1; n.gnt[w] = 1'b1;
      end else begin
        n.mode = 0;
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_models();
    check("dut8 gnt", 32'(gnt8), 32'(m8.gnt));
    check("dut8 hold_err", 32'(herr8), 32'(m8.herr));
    check("dut8 bus_busy", 32'(busy8), 32'(|m8.gnt));
    if (m8.mode == 1) check("dut8 owner", 32'(owner8), 32'(m8.owner));
    check("dut3 gnt", 32'(gnt3), 32'(m3.gnt));
    check("dut3 hold_err", 32'(herr3), 32'(m3.herr));
    check("dut3 bus_busy", 32'(busy3), 32'(|m3.gnt));
    if (m3.mode == 1) check("dut3 owner", 32'(owner3), 32'(m3.owner));
  endtask

  // Apply requests for one edge, advance the models, compare #1 after the edge.
  task automatic tick(input logic [3:0] r8, input logic [3:0] r3);
    req8 = r8;
    req3 = r3;
    @(posedge clk);
    if (reset) begin
      m8 = mstep(m8, r8, 8);
      m3 = mstep(m3, r3, 3);
    end
    #1;
    compare_models();
  endtask

  task automatic run_vecs(input vec_t v[$], input bit on3, input string tag, output int herrs);
    herrs = 0;
    foreach (v[i]) begin
      if (on3) tick(4'b0000, v[i].req);
      else     tick(v[i].req, 4'b0000);
      check({tag, " gnt"}, 32'(on3 ? gnt3 : gnt8), 32'(v[i].gnt));
      check({tag, " hold_err"}, 32'(on3 ? herr3 : herr8), 32'(v[i].herr));
      herrs += int'(on3 ? herr3 : herr8);
    end
  endtask

  always @(negedge clk) begin
    check("onehot0 gnt8", 32'($onehot0(gnt8)), 32'd1);
    check("onehot0 gnt3", 32'($onehot0(gnt3)), 32'd1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    vec_t rot[$];
    vec_t solo[$];
    int   herrs;
    logic [3:0] r8, r3;

    // Rotation with every requester active: 8 grants each, dead cycle with hold_err.
    for (int o = 0; o < 4; o++) begin
      for (int k = (o == 0) ? 1 : 0; k < 8; k++) rot.push_back('{4'b1111, 4'(1 << o), 1'b0});
      rot.push_back('{4'b1111, 4'b0000, 1'b1});
    end
    rot.push_back('{4'b1111, 4'b0001, 1'b0});
    // Sole requester, limit 3: three grants then a dead cycle, repeated.
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 3; k++) solo.push_back('{4'b0010, 4'b0010, 1'b0});
      solo.push_back('{4'b0010, 4'b0000, 1'b1});
    end
    solo.push_back('{4'b0010, 4'b0010, 1'b0});

    // 1: reset with all requests high.
    reset = 1'b0;
    req8  = 4'b1111;
    req3  = 4'b1111;
    m8    = mreset();
    m3    = mreset();
    repeat (2) @(posedge clk);
    #1;
    check("reset gnt8", 32'(gnt8), 32'd0);
    check("reset busy8", 32'(busy8), 32'd0);
    check("reset hold_err8", 32'(herr8), 32'd0);
    check("reset gnt3", 32'(gnt3), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick(4'b1111, 4'b0000);
    check("first grant after reset", 32'(gnt8), 32'b0001);

    // 2: rotation.
    run_vecs(rot, 1'b0, "rotation", herrs);
    check("rotation hold_err pulses", 32'(herrs), 32'd4);

    // 3: release and wrap. Park the pointer at 3 via a tenure of requester 2.
    tick(4'b0000, 4'b0000);
    tick(4'b0000, 4'b0000);
    tick(4'b0100, 4'b0000);
    tick(4'b0000, 4'b0000);
    tick(4'b0000, 4'b0000);
    tick(4'b0101, 4'b0000);
    check("wrap pick gnt", 32'(gnt8), 32'b0001);
    tick(4'b0101, 4'b0000);
    tick(4'b0100, 4'b0000);
    check("release dead cycle", 32'(gnt8), 32'b0000);
    check("release no hold_err", 32'(herr8), 32'd0);
    tick(4'b0100, 4'b0000);
    check("release next owner", 32'(gnt8), 32'b0100);

    // 4: requester 1 drops on the same edge the limit would cut it.
    tick(4'b0000, 4'b0000);
    tick(4'b0000, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      tick(4'b0010, 4'b0000);
      check("coincidence tenure gnt", 32'(gnt8), 32'b0010);
    end
    tick(4'b0000, 4'b0000);
    check("coincidence gnt", 32'(gnt8), 32'b0000);
    check("coincidence hold_err", 32'(herr8), 32'd0);

    // 5: sole requester timeout on the MAX_HOLD=3 instance.
    run_vecs(solo, 1'b1, "sole timeout", herrs);
    check("sole timeout hold_err pulses", 32'(herrs), 32'd3);

    // 6: async reset mid-tenure, pointer returns to 0.
    tick(4'b1010, 4'b0000);
    check("pre-reset owner", 32'(gnt8), 32'b1000);
    tick(4'b1010, 4'b0000);
    #2;
    reset = 1'b0;
    #1;
    check("async reset gnt8", 32'(gnt8), 32'd0);
    check("async reset busy8", 32'(busy8), 32'd0);
    check("async reset hold_err8", 32'(herr8), 32'd0);
    m8 = mreset();
    m3 = mreset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick(4'b1010, 4'b0000);
    check("post-reset lowest index", 32'(gnt8), 32'b0010);

    // Randomized requests against the model.
    r8 = 4'b1010;
    r3 = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r8 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r3 = 4'($urandom_range(0, 15));
      tick(r8, r3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
